// File: rtl/memory_32_6_arbiter.sv
// Two-requester arbiter and read-return sequencer for memory_32_6 (64x32, 2-cycle read).
// One grant per cycle; read tags ride a 2-stage pipe aligned to the memory's read latency.

package memory_32_6_pkg;
   typedef struct packed {
      logic       wr_vld;
      logic [5:0] wr_address;
      logic [5:0] rd_address;
   } m_32_6;
endpackage

module memory_32_6_arbiter
   import memory_32_6_pkg::*;
#(
   parameter bit FIXED_PRI = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_vld,
   output logic        req0_rdy,
   input  logic        req0_wr,
   input  logic [5:0]  req0_addr,
   input  logic [31:0] req0_wr_data,
   input  logic        req1_vld,
   output logic        req1_rdy,
   input  logic        req1_wr,
   input  logic [5:0]  req1_addr,
   input  logic [31:0] req1_wr_data,
   output logic        rsp0_vld,
   output logic [31:0] rsp0_data,
   output logic        rsp1_vld,
   output logic [31:0] rsp1_data,
   output m_32_6       m,
   output logic [31:0] m_wr_data,
   input  logic [31:0] m_rd_data,
   output logic        busy
);
   localparam int NUM_REQ = 2;
   localparam int STAGES  = 2;

   logic [NUM_REQ-1:0]        req_vld, req_wr, gnt, rsp_vld;
   logic [NUM_REQ-1:0][5:0]   req_addr;
   logic [NUM_REQ-1:0][31:0]  req_wdata;

   logic                      sel, xfer, issue_rd;
   logic                      rr_q, rr_d;
   logic [STAGES:1]           vld_pipe_q;
   logic [STAGES:1]           id_pipe_q;

   assign req_vld   = {req1_vld, req0_vld};
   assign req_wr    = {req1_wr, req0_wr};
   assign req_addr  = {req1_addr, req0_addr};
   assign req_wdata = {req1_wr_data, req0_wr_data};

   // Winner index: rr pointer (or requester 0) only matters under contention.
   always_comb begin
      sel = (&req_vld) ? (FIXED_PRI ? 1'b0 : rr_q) : req_vld[1];
      gnt = '0;
      if (reset && req_vld[sel]) gnt[sel] = 1'b1;
      xfer     = |gnt;
      issue_rd = xfer & ~req_wr[sel];
      rr_d     = xfer ? ~sel : rr_q;
   end

   assign req0_rdy = gnt[0];
   assign req1_rdy = gnt[1];

   always_comb begin
      m         = '0;
      m_wr_data = '0;
      if (xfer) begin
         if (req_wr[sel]) begin
            m.wr_vld     = 1'b1;
            m.wr_address = req_addr[sel];
            m_wr_data    = req_wdata[sel];
         end else begin
            m.rd_address = req_addr[sel];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_q       <= 1'b0;
         vld_pipe_q <= '0;
         id_pipe_q  <= '0;
      end else begin
         rr_q       <= rr_d;
         vld_pipe_q <= {vld_pipe_q[STAGES-1:1], issue_rd};
         id_pipe_q  <= {id_pipe_q[STAGES-1:1], sel};
      end
   end

   // The last pipe stage lines up with m_rd_data of the tagged read.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
      assign rsp_vld[i] = vld_pipe_q[STAGES] & (id_pipe_q[STAGES] == 1'(i));
   end

   assign rsp0_vld  = rsp_vld[0];
   assign rsp1_vld  = rsp_vld[1];
   assign rsp0_data = rsp_vld[0] ? m_rd_data : '0;
   assign rsp1_data = rsp_vld[1] ? m_rd_data : '0;
   assign busy      = |vld_pipe_q;

endmodule
